rs_issue_queue: RTL and testbench
=================================

# rs_issue_queue

Reservation station feeding a single execution unit. Accepts decoded instructions whose operands are values or reorder-buffer tags, and captures pending operands from the reorder-buffer result broadcast (`done_rob`/`data_rob`). Dispatches ready entries to the ALU and publishes each result on `done_rs`/`data_rs` for the reorder buffer, keyed by the station index given to the ROB at issue. It is the producer side of the ROB's `done_rs`/`data_rs` interface and the consumer of its broadcast.

## Interface
- `rs_size`, 16, number of station entries
- `rs_index_bits`, 4, log2(rs_size)
- `rob_size`, 16, number of ROB entries
- `rob_index_bits`, 4, log2(rob_size)

Ports (one clock `clk`; reset `rst` is asynchronous and active-high):
- `clk` in 1 — clock
- `rst` in 1 — async active-high reset
- `issue_valid` in 1 — decoder presents an instruction
- `issue_ready` out 1 — a free entry exists (= ~`rs_full`)
- `issue_op` in 3 — ALU opcode
- `issue_rob_tag` in rob_index_bits — destination ROB entry
- `issue_src1_rdy`, `issue_src2_rdy` in 1 — operand is a value (1) or a ROB tag in bits [rob_index_bits-1:0] (0)
- `issue_src1`, `issue_src2` in 32 — value or tag
- `rs_alloc_idx` out 32 — zero-extended index of the entry the next issue takes; passed to the ROB as its station index
- `done_rob` in rob_size — ROB entry-valid vector
- `data_rob` in 32 [rob_size] — ROB entry data
- `alu_req_valid` out 1; `alu_req_ready` in 1
- `alu_op` out 3; `alu_a`, `alu_b` out 32; `alu_tag` out rs_index_bits
- `alu_resp_valid` in 1; `alu_resp_tag` in rs_index_bits; `alu_resp_data` in 32
- `done_rs` out rs_size — entry i has a result this cycle
- `data_rs` out 32 [rs_size] — per-entry result
- `rs_full` out 1 — no FREE entry

## Operation
- Per-entry state: FREE, WAIT (at least one operand pending), READY, ISSUED, DONE. Each entry stores op, rob_tag, and two operands, each with a rdy bit.
- Allocation: lowest-index FREE entry. `rs_alloc_idx` shows it combinationally. Issue fires on `issue_valid && issue_ready`.
- Issue-time capture: a tagged operand with `done_rob[tag]`=1 is captured from `data_rob[tag]` at issue.
- Wakeup: each cycle, every pending operand whose `done_rob[tag]`=1 captures `data_rob[tag]`. The entry moves WAIT→READY when both operands are rdy.
- Dispatch: when `alu_req_valid`=0, select the lowest-index READY entry. Hold `alu_*` stable until `alu_req_ready`. On handshake the entry becomes ISSUED.
- Completion: `alu_resp_valid` with the tag of an ISSUED entry latches `data_rs[tag]` and sets the entry to DONE. A response to a non-ISSUED entry is ignored.
- `done_rs[i]` = (state==DONE). DONE lasts exactly one cycle, then the entry goes to FREE.
- Simultaneous events: an entry freeing this cycle is not allocatable until the next cycle. Issue, wakeup, dispatch and completion to distinct entries all proceed in the same cycle.
- Reset mid-operation clears every entry to FREE. Later ALU responses are ignored.

## Timing
- Reset values: `issue_ready`=1, `rs_full`=0, `rs_alloc_idx`=0, `alu_req_valid`=0, `alu_*`=0, `done_rs`=0, `data_rs`=all 0.
- Issue in cycle N with both operands available: entry READY in N+1, `alu_req_valid` high in N+1.
- `done_rob[t]` rises in cycle N: the dependent operand is rdy in N+1, and the earliest request is in N+1.
- Response in cycle M: `done_rs[i]`=1 in M+1 only; entry FREE and allocatable in M+2.
- `data_rs[i]` holds its value after DONE until the entry is re-completed or reset.

## Configuration
- `RS_BYPASS_EN` defined: a response in cycle M also wakes every pending operand whose tag equals the completing entry's rob_tag. That operand captures `alu_resp_data` and is rdy in M+1. This saves 2 cycles versus the ROB round trip.
- `RS_BYPASS_EN` undefined: operands wake only via `done_rob`/`data_rob`.

## Test plan
- Reset with `issue_valid`=1 → `issue_ready`=1, `done_rs`=0, `alu_req_valid`=0 during reset; first issue after reset allocates `rs_alloc_idx`=0.
- Issue op=ADD, src1=5, src2=7 (both rdy), `alu_req_ready`=1, ALU answers 12 two cycles after the handshake → `alu_a`=5, `alu_b`=7, `alu_tag`=0; `done_rs[0]` pulses one cycle with `data_rs[0]`=12.
- Issue with src1 tag=3 and `done_rob[3]`=0 → no request. Then `done_rob[3]`=1 with `data_rob[3]`=0xDEAD → `alu_a`=0xDEAD, request the next cycle.
- Fill 16 entries with `alu_req_ready`=0 → `rs_full`=1 and `issue_ready`=0; the 17th issue is dropped. Complete entry 4 → `issue_ready`=1 two cycles after the response, and `rs_alloc_idx`=4.
- `alu_req_ready`=0 for 3 cycles while entries 2 and 5 are READY → `alu_tag`=2 and operands held stable throughout. A response with a stale tag of a FREE entry → no `done_rs`.
- With `RS_BYPASS_EN`: entry B waits on entry A's rob_tag; A's response at cycle M → B's request at M+1. Without `RS_BYPASS_EN`: B's request at M+3.

Source files
------------

// File: rtl/rs_issue_queue_if.sv
// Signal bundle around the reservation station: decoder issue port, ROB result
// broadcast in, per-entry results out to the ROB, and the ALU request/response pair.
// Modports: master = core side (decoder, ROB, ALU); slave = the station itself.
interface rs_issue_queue_if #(
    parameter int rs_size        = 16,
    parameter int rs_index_bits  = 4,
    parameter int rob_size       = 16,
    parameter int rob_index_bits = 4
);
    // decoder issue port
    logic                      issue_valid;
    logic                      issue_ready;
    logic [2:0]                issue_op;
    logic [rob_index_bits-1:0] issue_rob_tag;
    logic                      issue_src1_rdy;
    logic                      issue_src2_rdy;
    logic [31:0]               issue_src1;
    logic [31:0]               issue_src2;
    logic [31:0]               rs_alloc_idx;
    logic                      rs_full;
    // ROB broadcast
    logic [rob_size-1:0]       done_rob;
    logic [31:0]               data_rob [rob_size];
    // ALU request / response
    logic                      alu_req_valid;
    logic                      alu_req_ready;
    logic [2:0]                alu_op;
    logic [31:0]               alu_a;
    logic [31:0]               alu_b;
    logic [rs_index_bits-1:0]  alu_tag;
    logic                      alu_resp_valid;
    logic [rs_index_bits-1:0]  alu_resp_tag;
    logic [31:0]               alu_resp_data;
    // results towards the ROB
    logic [rs_size-1:0]        done_rs;
    logic [31:0]               data_rs [rs_size];

    modport master (
        output issue_valid, issue_op, issue_rob_tag, issue_src1_rdy, issue_src2_rdy,
               issue_src1, issue_src2, done_rob, data_rob, alu_req_ready,
               alu_resp_valid, alu_resp_tag, alu_resp_data,
        input  issue_ready, rs_alloc_idx, rs_full, alu_req_valid, alu_op, alu_a,
               alu_b, alu_tag, done_rs, data_rs
    );

    modport slave (
        input  issue_valid, issue_op, issue_rob_tag, issue_src1_rdy, issue_src2_rdy,
               issue_src1, issue_src2, done_rob, data_rob, alu_req_ready,
               alu_resp_valid, alu_resp_tag, alu_resp_data,
        output issue_ready, rs_alloc_idx, rs_full, alu_req_valid, alu_op, alu_a,
               alu_b, alu_tag, done_rs, data_rs
    );
endinterface

// File: rtl/rs_issue_queue.sv
// Reservation station for one ALU: holds issued ops, wakes operands from the ROB
// broadcast, dispatches lowest-index ready entry, reports results per entry.
// Latency: issue->request 1 cycle; response->done_rs 1 cycle; entry reusable 2 cycles after response.
// Backpressure: issue_ready low when full; alu_* held stable while alu_req_ready is low.
// Ports: clk, rst (async active-high), bus (rs_issue_queue_if.slave).
// Option: define RS_BYPASS_EN to wake waiting operands directly from the ALU response.
module rs_issue_queue #(
    parameter int rs_size        = 16,
    parameter int rs_index_bits  = 4,
    parameter int rob_size       = 16,
    parameter int rob_index_bits = 4
) (
    input  logic              clk,
    input  logic              rst,
    rs_issue_queue_if.slave   bus
);
    typedef enum logic [2:0] {S_FREE, S_WAIT, S_READY, S_ISSUED, S_DONE} state_t;

    state_t                    st_q    [rs_size];
    logic [2:0]                op_q    [rs_size];
    logic [rob_index_bits-1:0] tag_q   [rs_size];
    logic [31:0]               a_q     [rs_size];
    logic [31:0]               b_q     [rs_size];
    logic                      a_rdy_q [rs_size];
    logic                      b_rdy_q [rs_size];
    logic [31:0]               data_q  [rs_size];

    logic                      alu_vld_q;
    logic [2:0]                alu_op_q;
    logic [31:0]               alu_a_q;
    logic [31:0]               alu_b_q;
    logic [rs_index_bits-1:0]  alu_tag_q;

    // Next-cycle view of every entry after this cycle's issue and wakeup.
    logic [2:0]                n_op    [rs_size];
    logic [31:0]               n_a     [rs_size];
    logic [31:0]               n_b     [rs_size];
    logic                      n_a_rdy [rs_size];
    logic                      n_b_rdy [rs_size];
    logic [rs_size-1:0]        new_here;
    logic [rs_size-1:0]        cand;

    logic [rs_index_bits-1:0]  alloc_idx;
    logic                      any_free;
    logic [rs_index_bits-1:0]  sel_idx;
    logic                      sel_vld;
    logic                      issue_fire;
    logic                      alu_fire;
    logic                      resp_hit;
    logic                      byp_en;
    logic [rob_index_bits-1:0] resp_rob_tag;

    // Only entries FREE at the start of the cycle count, so a DONE entry is not
    // reusable until the cycle after it frees.
    always_comb begin
        alloc_idx = '0;
        any_free  = 1'b0;
        for (int i = rs_size - 1; i >= 0; i--) begin
            if (st_q[i] == S_FREE) begin
                alloc_idx = rs_index_bits'(i);
                any_free  = 1'b1;
            end
        end
    end

    assign issue_fire   = bus.issue_valid && any_free;
    assign alu_fire     = alu_vld_q && bus.alu_req_ready;
    assign resp_hit     = bus.alu_resp_valid && (st_q[bus.alu_resp_tag] == S_ISSUED);
    assign resp_rob_tag = tag_q[bus.alu_resp_tag];

`ifdef RS_BYPASS_EN
    assign byp_en = resp_hit;
`else
    assign byp_en = 1'b0;
`endif

    function automatic logic [32:0] wake(input logic rdy, input logic [31:0] v,
                                         input logic rob_hit, input logic [31:0] rob_val,
                                         input logic byp_hit, input logic [31:0] byp_val);
        if (rdy)     return {1'b1, v};
        if (rob_hit) return {1'b1, rob_val};
        if (byp_hit) return {1'b1, byp_val};
        return {1'b0, v};
    endfunction

    for (genvar g = 0; g < rs_size; g++) begin : g_ent
        logic                      here;
        logic                      pending;
        logic                      ra;
        logic                      rb;
        logic [31:0]               sa;
        logic [31:0]               sb;
        logic [rob_index_bits-1:0] ta;
        logic [rob_index_bits-1:0] tb;

        assign here    = issue_fire && (alloc_idx == rs_index_bits'(g));
        assign pending = here || (st_q[g] == S_WAIT);
        assign ra      = here ? bus.issue_src1_rdy : a_rdy_q[g];
        assign rb      = here ? bus.issue_src2_rdy : b_rdy_q[g];
        assign sa      = here ? bus.issue_src1 : a_q[g];
        assign sb      = here ? bus.issue_src2 : b_q[g];
        assign ta      = sa[rob_index_bits-1:0];
        assign tb      = sb[rob_index_bits-1:0];

        assign {n_a_rdy[g], n_a[g]} = pending
            ? wake(ra, sa, bus.done_rob[ta], bus.data_rob[ta], byp_en && (ta == resp_rob_tag), bus.alu_resp_data)
            : {a_rdy_q[g], a_q[g]};
        assign {n_b_rdy[g], n_b[g]} = pending
            ? wake(rb, sb, bus.done_rob[tb], bus.data_rob[tb], byp_en && (tb == resp_rob_tag), bus.alu_resp_data)
            : {b_rdy_q[g], b_q[g]};

        assign n_op[g]     = here ? bus.issue_op : op_q[g];
        assign new_here[g] = here;
        // Entries becoming ready this cycle are eligible now, giving a request the next cycle.
        assign cand[g]     = (st_q[g] == S_READY) || (pending && n_a_rdy[g] && n_b_rdy[g]);
        assign bus.done_rs[g] = (st_q[g] == S_DONE);
    end

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = rs_size - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_vld = 1'b1;
                sel_idx = rs_index_bits'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < rs_size; i++) begin
                st_q[i]    <= S_FREE;
                op_q[i]    <= '0;
                tag_q[i]   <= '0;
                a_q[i]     <= '0;
                b_q[i]     <= '0;
                a_rdy_q[i] <= 1'b0;
                b_rdy_q[i] <= 1'b0;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < rs_size; i++) begin
                op_q[i]    <= n_op[i];
                a_q[i]     <= n_a[i];
                b_q[i]     <= n_b[i];
                a_rdy_q[i] <= n_a_rdy[i];
                b_rdy_q[i] <= n_b_rdy[i];
                if (new_here[i]) tag_q[i] <= bus.issue_rob_tag;
                case (st_q[i])
                    S_FREE:   if (new_here[i])
                                  st_q[i] <= (n_a_rdy[i] && n_b_rdy[i]) ? S_READY : S_WAIT;
                    S_WAIT:   if (n_a_rdy[i] && n_b_rdy[i]) st_q[i] <= S_READY;
                    S_READY:  if (alu_fire && (alu_tag_q == rs_index_bits'(i))) st_q[i] <= S_ISSUED;
                    S_ISSUED: if (resp_hit && (bus.alu_resp_tag == rs_index_bits'(i))) begin
                                  st_q[i]   <= S_DONE;
                                  data_q[i] <= bus.alu_resp_data;
                              end
                    default:  st_q[i] <= S_FREE;
                endcase
            end
        end
    end

    // A new request is only chosen while the slot is empty, so the payload never
    // changes under a stalled request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_vld_q <= 1'b0;
            alu_op_q  <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_tag_q <= '0;
        end else if (alu_fire) begin
            alu_vld_q <= 1'b0;
        end else if (!alu_vld_q && sel_vld) begin
            alu_vld_q <= 1'b1;
            alu_op_q  <= n_op[sel_idx];
            alu_a_q   <= n_a[sel_idx];
            alu_b_q   <= n_b[sel_idx];
            alu_tag_q <= sel_idx;
        end
    end

    assign bus.issue_ready   = any_free;
    assign bus.rs_full       = !any_free;
    assign bus.rs_alloc_idx  = 32'(alloc_idx);
    assign bus.alu_req_valid = alu_vld_q;
    assign bus.alu_op        = alu_op_q;
    assign bus.alu_a         = alu_a_q;
    assign bus.alu_b         = alu_b_q;
    assign bus.alu_tag       = alu_tag_q;
    assign bus.data_rs       = data_q;
endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue: table of single-instruction vectors plus
// hand-written sequences for wakeup, full/backpressure, stale responses, reset and bypass timing.
// The bench plays decoder, ROB and ALU.
module tb_rs_issue_queue;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rs_issue_queue_if #(.rs_size(16), .rs_index_bits(4), .rob_size(16), .rob_index_bits(4)) bus ();
    rs_issue_queue #(.rs_size(16), .rs_index_bits(4), .rob_size(16), .rob_index_bits(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  op;
        logic        r1;
        logic [31:0] s1;
        logic        r2;
        logic [31:0] s2;
        logic [15:0] rob;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] res;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.issue_valid    = 1'b0;
        bus.issue_op       = '0;
        bus.issue_rob_tag  = '0;
        bus.issue_src1_rdy = 1'b1;
        bus.issue_src2_rdy = 1'b1;
        bus.issue_src1     = '0;
        bus.issue_src2     = '0;
        bus.done_rob       = '0;
        for (int k = 0; k < 16; k++) bus.data_rob[k] = 32'hD000 + k;
        bus.alu_req_ready  = 1'b0;
        bus.alu_resp_valid = 1'b0;
        bus.alu_resp_tag   = '0;
        bus.alu_resp_data  = '0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] rt, input logic r1,
                         input logic [31:0] s1, input logic r2, input logic [31:0] s2);
        bus.issue_valid    = 1'b1;
        bus.issue_op       = op;
        bus.issue_rob_tag  = rt;
        bus.issue_src1_rdy = r1;
        bus.issue_src1     = s1;
        bus.issue_src2_rdy = r2;
        bus.issue_src2     = s2;
    endtask

    task automatic respond(input logic [3:0] tag, input logic [31:0] d);
        bus.alu_resp_valid = 1'b1;
        bus.alu_resp_tag   = tag;
        bus.alu_resp_data  = d;
        tick();
        bus.alu_resp_valid = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want summary");
        $fatal(1, "timeout");
    end

    initial begin
        int   cnt;
        int   seen;
        logic [31:0] a_seen;

        tbl[0] = '{3'd0, 1'b1, 32'd5,          1'b1, 32'd7,  16'h0000, 32'd5,      32'd7,      32'd12};
        tbl[1] = '{3'd1, 1'b1, 32'd100,        1'b1, 32'd1,  16'h0000, 32'd100,    32'd1,      32'd99};
        tbl[2] = '{3'd2, 1'b0, 32'hABCD0003,   1'b1, 32'hFF, 16'h0008, 32'hD003,   32'hFF,     32'h03};
        tbl[3] = '{3'd3, 1'b1, 32'hF0,         1'b0, 32'h9,  16'h0200, 32'hF0,     32'hD009,   32'hD0F9};
        tbl[4] = '{3'd4, 1'b0, 32'd1,          1'b0, 32'd14, 16'h4002, 32'hD001,   32'hD00E,   32'h000F};

        // reset with issue_valid held high
        rst = 1'b1;
        idle();
        issue(3'd0, 4'd1, 1'b1, 32'd1, 1'b1, 32'd2);
        tick();
        chk("rst issue_ready", bus.issue_ready, 1);
        chk("rst rs_full", bus.rs_full, 0);
        chk("rst done_rs", bus.done_rs, 0);
        chk("rst alu_req_valid", bus.alu_req_valid, 0);
        chk("rst alloc", bus.rs_alloc_idx, 0);
        chk("rst alu_a", bus.alu_a, 0);
        chk("rst data_rs0", bus.data_rs[0], 0);
        tick();
        bus.issue_valid = 1'b0;
        rst = 1'b0;
        tick();

        // table: one instruction at a time through issue, dispatch, completion
        bus.alu_req_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            chk($sformatf("v%0d alloc", v), bus.rs_alloc_idx, 0);
            issue(tbl[v].op, 4'(v), tbl[v].r1, tbl[v].s1, tbl[v].r2, tbl[v].s2);
            bus.done_rob = tbl[v].rob;
            tick();
            bus.issue_valid = 1'b0;
            bus.done_rob    = '0;
            chk($sformatf("v%0d req_valid", v), bus.alu_req_valid, 1);
            chk($sformatf("v%0d alu_a", v), bus.alu_a, tbl[v].exp_a);
            chk($sformatf("v%0d alu_b", v), bus.alu_b, tbl[v].exp_b);
            chk($sformatf("v%0d alu_op", v), bus.alu_op, tbl[v].op);
            chk($sformatf("v%0d alu_tag", v), bus.alu_tag, 0);
            tick();
            chk($sformatf("v%0d req drop", v), bus.alu_req_valid, 0);
            tick();
            respond(4'd0, tbl[v].res);
            chk($sformatf("v%0d done_rs", v), bus.done_rs, 16'h0001);
            chk($sformatf("v%0d data_rs", v), bus.data_rs[0], tbl[v].res);
            tick();
            chk($sformatf("v%0d done_rs off", v), bus.done_rs, 0);
            chk($sformatf("v%0d data_rs hold", v), bus.data_rs[0], tbl[v].res);
        end

        // wakeup from ROB broadcast
        issue(3'd1, 4'd2, 1'b0, 32'd3, 1'b1, 32'd1);
        tick();
        bus.issue_valid = 1'b0;
        chk("wake no req 1", bus.alu_req_valid, 0);
        tick();
        chk("wake no req 2", bus.alu_req_valid, 0);
        bus.done_rob[3] = 1'b1;
        bus.data_rob[3] = 32'hDEAD;
        tick();
        bus.done_rob    = '0;
        bus.data_rob[3] = 32'hD003;
        chk("wake req", bus.alu_req_valid, 1);
        chk("wake alu_a", bus.alu_a, 32'hDEAD);
        chk("wake alu_b", bus.alu_b, 1);
        tick();
        tick();
        respond(4'd0, 32'hDEAC);
        chk("wake done_rs", bus.done_rs, 16'h0001);
        tick();

        // fill all entries with the ALU stalled
        do_reset();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fill alloc %0d", i), bus.rs_alloc_idx, i);
            issue(3'd0, 4'(i), 1'b1, i, 1'b1, 100 + i);
            tick();
        end
        chk("full rs_full", bus.rs_full, 1);
        chk("full issue_ready", bus.issue_ready, 0);
        issue(3'd0, 4'd15, 1'b1, 32'd99, 1'b1, 32'd99);
        tick();
        bus.issue_valid = 1'b0;
        chk("17th dropped full", bus.rs_full, 1);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d valid", c), bus.alu_req_valid, 1);
            chk($sformatf("stall%0d tag", c), bus.alu_tag, 0);
            chk($sformatf("stall%0d a", c), bus.alu_a, 0);
            chk($sformatf("stall%0d b", c), bus.alu_b, 100);
            tick();
        end
        bus.alu_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cnt = 0;
            while (!bus.alu_req_valid && cnt < 4) begin
                tick();
                cnt++;
            end
            chk($sformatf("drain%0d tag", k), bus.alu_tag, k);
            chk($sformatf("drain%0d a", k), bus.alu_a, k);
            tick();
        end
        bus.alu_req_ready = 1'b0;
        respond(4'd4, 32'h44);
        chk("c4 done_rs", bus.done_rs, 16'h0010);
        chk("c4 data_rs", bus.data_rs[4], 32'h44);
        chk("c4 not free yet", bus.issue_ready, 0);
        tick();
        chk("c4 issue_ready", bus.issue_ready, 1);
        chk("c4 alloc", bus.rs_alloc_idx, 4);
        chk("c4 done_rs off", bus.done_rs, 0);
        respond(4'd4, 32'h55);
        chk("stale free done_rs", bus.done_rs, 0);
        chk("stale free data_rs", bus.data_rs[4], 32'h44);
        respond(4'd7, 32'h77);
        chk("stale ready done_rs", bus.done_rs, 0);
        chk("stale ready data_rs", bus.data_rs[7], 0);
        chk("held valid", bus.alu_req_valid, 1);
        chk("held tag", bus.alu_tag, 5);
        chk("held a", bus.alu_a, 5);
        chk("held b", bus.alu_b, 105);

        // asynchronous reset mid-operation
        rst = 1'b1;
        #1;
        chk("midrst valid", bus.alu_req_valid, 0);
        chk("midrst rs_full", bus.rs_full, 0);
        chk("midrst alloc", bus.rs_alloc_idx, 0);
        chk("midrst data_rs4", bus.data_rs[4], 0);
        tick();
        rst = 1'b0;
        respond(4'd0, 32'h99);
        chk("post-rst resp ignored", bus.done_rs, 0);
        tick();

        // dependent op: bypass vs ROB round trip
        bus.alu_req_ready = 1'b1;
        issue(3'd0, 4'd6, 1'b1, 32'd1, 1'b1, 32'd2);
        tick();
        issue(3'd0, 4'd7, 1'b0, 32'd6, 1'b1, 32'd10);
        chk("dep A req", bus.alu_req_valid, 1);
        chk("dep A tag", bus.alu_tag, 0);
        tick();
        bus.issue_valid   = 1'b0;
        bus.alu_req_ready = 1'b0;
        respond(4'd0, 32'd3);
        chk("dep A done_rs", bus.done_rs, 16'h0001);
        seen   = 0;
        a_seen = '0;
        for (int c = 1; c <= 6; c++) begin
            if (seen == 0 && bus.alu_req_valid && bus.alu_tag == 4'd1) begin
                seen   = c;
                a_seen = bus.alu_a;
            end
            if (c == 2) begin
                bus.done_rob[6] = 1'b1;
                bus.data_rob[6] = 32'd3;
            end
            tick();
        end
`ifdef RS_BYPASS_EN
        chk("dep B request cycle", seen, 1);
`else
        chk("dep B request cycle", seen, 3);
`endif
        chk("dep B alu_a", a_seen, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
